// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory access sequencer.
package mem_access_pkg;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_W    = 3'b001;
    localparam logic [2:0] LD_BU   = 3'b010;
    localparam logic [2:0] LD_HU   = 3'b011;
    localparam logic [2:0] LD_B    = 3'b100;
    localparam logic [2:0] LD_H    = 3'b101;

    localparam logic [1:0] ST_B    = 2'b00;
    localparam logic [1:0] ST_H    = 2'b01;
    localparam logic [1:0] ST_W    = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Map a load code onto the access size, using the store size encoding.
    function automatic logic [1:0] load_size(input logic [2:0] ld);
        case (ld)
            LD_W:        return ST_W;
            LD_BU, LD_B: return ST_B;
            LD_HU, LD_H: return ST_H;
            default:     return ST_NONE;
        endcase
    endfunction

    // Natural alignment check for a given access size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            ST_W:    return (a == 2'b00);
            ST_H:    return ~a[0];
            default: return 1'b1;
        endcase
    endfunction

    // Byte enables for an access of the given size at byte lane.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            ST_B:    return 4'b0001 << lane;
            ST_H:    return 4'b0011 << lane;
            ST_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across all lanes.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            ST_B:    return {4{wdata[7:0]}};
            ST_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and memory-port handshake bundle.
interface mem_access_ctrl_if;
    logic        ReqValid;
    logic        ReqWrite;
    logic [2:0]  LoadSignal;
    logic [1:0]  StoreSize;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Stall;
    logic        RspValid;
    logic [31:0] RData;
    logic        AlignErr;
    logic        TimeoutErr;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBE;
    logic [31:0] MemWData;
    logic        MemGnt;
    logic        MemRValid;
    logic [31:0] MemRData;

    modport slave (
        input  ReqValid, ReqWrite, LoadSignal, StoreSize, Addr, WData,
        input  MemGnt, MemRValid, MemRData,
        output Stall, RspValid, RData, AlignErr, TimeoutErr,
        output MemReq, MemWe, MemAddr, MemBE, MemWData
    );

    modport master (
        output ReqValid, ReqWrite, LoadSignal, StoreSize, Addr, WData,
        output MemGnt, MemRValid, MemRData,
        input  Stall, RspValid, RData, AlignErr, TimeoutErr,
        input  MemReq, MemWe, MemAddr, MemBE, MemWData
    );
endinterface

// File: rtl/mem_access_ctrl_lane_extract_extend.sv
// Selects the addressed byte/half from a read word and extends it per load type.
module lane_extract_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  ld_code,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by zero/sign extension.
    always_comb begin
        byte_sel = 8'(word >> {lane, 3'b000});
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (ld_code)
            LD_W:    result = word;
            LD_BU:   result = {24'h0, byte_sel};
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_HU:   result = {16'h0, half_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store sequencer between the MEM stage and a handshaked data memory.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [2:0]         ld_q, ld_d;
    logic [1:0]         lane_q, lane_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               align_err_q, align_err_d;
    logic               timeout_err_q, timeout_err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic [1:0]         req_size;
    logic               req_ok;
    logic               stall_c;
    logic [31:0]        ext_data;

    lane_extract_extend u_extract (
        .word    (bus.MemRData),
        .lane    (lane_q),
        .ld_code (ld_q),
        .result  (ext_data)
    );

    // Next-state, request latching and response generation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        ld_d          = ld_q;
        lane_d        = lane_q;
        rsp_valid_d   = 1'b0;
        align_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        rdata_d       = rdata_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        stall_c       = 1'b0;

        req_size = bus.ReqWrite ? bus.StoreSize : load_size(bus.LoadSignal);
        req_ok   = bus.ReqValid && (req_size != ST_NONE);

        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    stall_c = 1'b1;
                    if (!is_aligned(req_size, bus.Addr[1:0])) begin
                        state_d     = S_ERR;
                        align_err_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        write_d     = bus.ReqWrite;
                        ld_d        = bus.ReqWrite ? LD_NONE : bus.LoadSignal;
                        lane_d      = bus.Addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.ReqWrite;
                        mem_addr_d  = {bus.Addr[31:2], 2'b00};
                        mem_be_d    = byte_en(req_size, bus.Addr[1:0]);
                        mem_wdata_d = bus.ReqWrite ? lane_data(req_size, bus.WData) : 32'h0;
                    end
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (bus.MemGnt) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_be_d    = 4'h0;
                    mem_wdata_d = 32'h0;
                    if (write_q) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rdata_d     = 32'h0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (bus.MemRValid) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = ext_data;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = S_ERR;
                    timeout_err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                stall_c = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            ld_q          <= LD_NONE;
            lane_q        <= 2'b00;
            rsp_valid_q   <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            rdata_q       <= 32'h0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_be_q      <= 4'h0;
            mem_wdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            ld_q          <= ld_d;
            lane_q        <= lane_d;
            rsp_valid_q   <= rsp_valid_d;
            align_err_q   <= align_err_d;
            timeout_err_q <= timeout_err_d;
            rdata_q       <= rdata_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign bus.Stall      = stall_c;
    assign bus.RspValid   = rsp_valid_q;
    assign bus.RData      = rdata_q;
    assign bus.AlignErr   = align_err_q;
    assign bus.TimeoutErr = timeout_err_q;
    assign bus.MemReq     = mem_req_q;
    assign bus.MemWe      = mem_we_q;
    assign bus.MemAddr    = mem_addr_q;
    assign bus.MemBE      = mem_be_q;
    assign bus.MemWData   = mem_wdata_q;

endmodule
